// File: rtl/multiplier_iterative.sv
// Iterative shift-add multiplier: fixed-point multiplicand a_i times integer
// multiplier b_i. One multiplier bit is consumed per cycle. Operands enter
// through a valid/ready handshake, and the product leaves through a second one.
// In signed mode the datapath works on magnitudes. The sign is reapplied once,
// when the result is captured.
module multiplier_iterative #(
  parameter int width_p  = 8,
  parameter int frac_p   = 4,
  parameter int signed_p = 0
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [width_p-1:-frac_p]      a_i,
  input  logic [width_p-1:0]            b_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [2*width_p-1:-frac_p]    product_o
);

  localparam int a_w_lp    = width_p + frac_p;
  localparam int prod_w_lp = 2 * width_p + frac_p;
  localparam int cnt_w_lp  = $clog2(width_p + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                 state_r, state_next_s;
  logic [prod_w_lp-1:0]   acc_r, acc_next_s;
  logic [prod_w_lp-1:0]   mcand_r, mcand_next_s;
  logic [width_p-1:0]     mplier_r, mplier_next_s;
  logic [cnt_w_lp-1:0]    cnt_r, cnt_next_s;
  logic                   neg_r, neg_next_s;
  logic [prod_w_lp-1:0]   prod_r, prod_next_s;
  logic                   ready_r;
  logic                   valid_r;

  logic [a_w_lp-1:0]      a_raw_s;
  logic [a_w_lp-1:0]      a_mag_s;
  logic [width_p-1:0]     b_mag_s;
  logic                   a_neg_s;
  logic                   b_neg_s;

  // Operand preparation: compute magnitudes and sign flags in signed mode.
  always_comb begin
    a_raw_s = a_i;
    if (signed_p != 0) begin
      a_neg_s = a_raw_s[a_w_lp-1];
      b_neg_s = b_i[width_p-1];
    end else begin
      a_neg_s = 1'b0;
      b_neg_s = 1'b0;
    end
    a_mag_s = a_neg_s ? (~a_raw_s + a_w_lp'(1'b1)) : a_raw_s;
    b_mag_s = b_neg_s ? (~b_i + width_p'(1'b1)) : b_i;
  end

  // Next-state and datapath update. Hold all values by default.
  always_comb begin
    state_next_s  = state_r;
    acc_next_s    = acc_r;
    mcand_next_s  = mcand_r;
    mplier_next_s = mplier_r;
    cnt_next_s    = cnt_r;
    neg_next_s    = neg_r;
    prod_next_s   = prod_r;
    case (state_r)
      ST_IDLE: begin
        if (valid_i && ready_r) begin
          acc_next_s    = {prod_w_lp{1'b0}};
          mcand_next_s  = prod_w_lp'(a_mag_s);
          mplier_next_s = b_mag_s;
          cnt_next_s    = cnt_w_lp'(width_p);
          neg_next_s    = a_neg_s ^ b_neg_s;
          state_next_s  = ST_BUSY;
        end else begin
          state_next_s  = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // The multiplicand register is pre-shifted each cycle, so it always
        // holds a_mag << (current iteration index).
        if (mplier_r[0]) begin
          acc_next_s = acc_r + mcand_r;
        end else begin
          acc_next_s = acc_r;
        end
        mcand_next_s  = mcand_r << 1;
        mplier_next_s = mplier_r >> 1;
        cnt_next_s    = cnt_r - cnt_w_lp'(1'b1);
        if (cnt_r == cnt_w_lp'(1'b1)) begin
          state_next_s = ST_DONE;
          prod_next_s  = neg_r ? (~acc_next_s + prod_w_lp'(1'b1)) : acc_next_s;
        end else begin
          state_next_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (ready_i) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= ST_IDLE;
      acc_r    <= {prod_w_lp{1'b0}};
      mcand_r  <= {prod_w_lp{1'b0}};
      mplier_r <= {width_p{1'b0}};
      cnt_r    <= {cnt_w_lp{1'b0}};
      neg_r    <= 1'b0;
      prod_r   <= {prod_w_lp{1'b0}};
      ready_r  <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      acc_r    <= acc_next_s;
      mcand_r  <= mcand_next_s;
      mplier_r <= mplier_next_s;
      cnt_r    <= cnt_next_s;
      neg_r    <= neg_next_s;
      prod_r   <= prod_next_s;
      ready_r  <= (state_next_s == ST_IDLE);
      valid_r  <= (state_next_s == ST_DONE);
    end
  end

  assign ready_o   = ready_r;
  assign valid_o   = valid_r;
  assign product_o = prod_r;

endmodule
